// File: rtl/maxpool_stream_if.sv
`timescale 1ns/1ps
// Pixel stream bundle for maxpool_stream: input beats in, pooled beats out.
// The master side feeds pixels and consumes results; the slave side is the pooler.
interface maxpool_stream_if #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*BITWIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*BITWIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/maxpool_stream.sv
`timescale 1ns/1ps
// Streaming 2x2 / stride-2 max or floor-average pooler over raster-order pixels.
// Even rows fold column pairs into a half-width line buffer; odd rows close each window.
module maxpool_stream #(
    parameter int BITWIDTH  = 16,
    parameter int CHANNELS  = 2,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int POOL_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    maxpool_stream_if.slave bus
);
    localparam int DW   = CHANNELS * BITWIDTH;
    localparam int LBW  = BITWIDTH + POOL_MODE;
    localparam int HALF = IMG_W / 2;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_size
        $error("maxpool_stream: IMG_W and IMG_H must be even and at least 2");
    end
    if (POOL_MODE != 0 && POOL_MODE != 1) begin : g_bad_mode
        $error("maxpool_stream: POOL_MODE must be 0 (max) or 1 (average)");
    end

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DW-1:0]           hold;
    logic [CHANNELS*LBW-1:0] lbuf [HALF];
    logic [CHANNELS*LBW-1:0] lb_rd;
    logic [CHANNELS*LBW-1:0] pair;
    logic [DW-1:0]           pooled;
    logic [AW-1:0]           lb_idx;
    logic [DW-1:0]           out_data_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    accept;
    logic                    col_end;
    logic                    row_end;

    // Accepting only when the output slot is free or draining keeps every beat lossless.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign col_end      = (col == CW'(IMG_W - 1));
    assign row_end      = (row == RW'(IMG_H - 1));
    assign lb_idx       = AW'(col >> 1);
    assign lb_rd        = lbuf[lb_idx];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [BITWIDTH-1:0] h;
        logic signed [BITWIDTH-1:0] x;
        logic signed [BITWIDTH-1:0] q;
        logic signed [LBW-1:0]      p;
        logic signed [LBW-1:0]      l;

        assign h = hold[c*BITWIDTH +: BITWIDTH];
        assign x = bus.in_data[c*BITWIDTH +: BITWIDTH];
        assign l = lb_rd[c*LBW +: LBW];

        if (POOL_MODE == 0) begin : g_max
            assign p = (h > x) ? h : x;
            assign q = (p > l) ? p : l;
        end else begin : g_avg
            logic signed [BITWIDTH+1:0] s4;
            assign p  = {h[BITWIDTH-1], h} + {x[BITWIDTH-1], x};
            assign s4 = {p[LBW-1], p} + {l[LBW-1], l};
            // Arithmetic shift floors toward -inf; the quotient of four samples always fits.
            assign q  = BITWIDTH'(s4 >>> 2);
        end

        assign pair[c*LBW +: LBW]           = p;
        assign pooled[c*BITWIDTH +: BITWIDTH] = q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            col         <= '0;
            row         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (accept) begin
                col <= col_end ? '0 : col + CW'(1);
                if (col_end) begin
                    row <= row_end ? '0 : row + RW'(1);
                end
                // A window-closing load overrides the drain clear above.
                if (row[0] && col[0]) begin
                    out_data_q  <= pooled;
                    out_valid_q <= 1'b1;
                    out_last_q  <= row_end && col_end;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: hold and line buffer are always written before read, so they carry no reset.
        if (accept && !col[0]) begin
            hold <= bus.in_data;
        end
        if (accept && col[0] && !row[0]) begin
            lbuf[lb_idx] <= pair;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
endmodule
